// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MIPS memory stage: opcodes, exception codes, address map.
// Also holds the load/store decode and the E/M register layout.
package mem_stage_pkg;

    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_LHU = 6'h25;
    localparam logic [5:0] OP_SB  = 6'h28;
    localparam logic [5:0] OP_SH  = 6'h29;
    localparam logic [5:0] OP_SW  = 6'h2B;

    localparam logic [4:0] EXC_NONE = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_OV   = 5'd12;

    localparam logic [31:0] TC0_LO    = 32'h0000_7F00;
    localparam logic [31:0] TC0_HI    = 32'h0000_7F0B;
    localparam logic [31:0] TC1_LO    = 32'h0000_7F10;
    localparam logic [31:0] TC1_HI    = 32'h0000_7F1B;
    localparam logic [31:0] IG_LO     = 32'h0000_7F20;
    localparam logic [31:0] IG_HI     = 32'h0000_7F23;
    localparam logic [31:0] TC0_COUNT = 32'h0000_7F08;
    localparam logic [31:0] TC1_COUNT = 32'h0000_7F18;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } mem_size_t;

    typedef struct packed {
        logic      is_load;
        logic      is_store;
        mem_size_t size;
        logic      uns;
    } mem_op_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] alu_out;
        logic [31:0] wdata;
        logic [4:0]  write_reg;
        logic [4:0]  exc_code;
        logic        isdelay;
    } em_reg_t;

    function automatic mem_op_t decode_op(input logic [5:0] opcode);
        mem_op_t op;
        op = '{is_load: 1'b0, is_store: 1'b0, size: SZ_WORD, uns: 1'b0};
        case (opcode)
            OP_LW:   begin op.is_load  = 1'b1; op.size = SZ_WORD; end
            OP_LH:   begin op.is_load  = 1'b1; op.size = SZ_HALF; end
            OP_LHU:  begin op.is_load  = 1'b1; op.size = SZ_HALF; op.uns = 1'b1; end
            OP_LB:   begin op.is_load  = 1'b1; op.size = SZ_BYTE; end
            OP_LBU:  begin op.is_load  = 1'b1; op.size = SZ_BYTE; op.uns = 1'b1; end
            OP_SW:   begin op.is_store = 1'b1; op.size = SZ_WORD; end
            OP_SH:   begin op.is_store = 1'b1; op.size = SZ_HALF; end
            OP_SB:   begin op.is_store = 1'b1; op.size = SZ_BYTE; end
            default: ;
        endcase
        return op;
    endfunction

    function automatic logic in_range(input logic [31:0] a, input logic [31:0] lo,
                                      input logic [31:0] hi);
        return (a >= lo) && (a <= hi);
    endfunction

endpackage

// File: rtl/mem_align.sv
// Lane steering for the data bus: byte enables, store replication, load extract/extend.
// Purely combinational, zero latency; no flow control of its own.
module mem_align
    import mem_stage_pkg::*;
(
    input  mem_size_t   size,
    input  logic        uns,
    input  logic [1:0]  addr_lo,
    input  logic        store_en,
    input  logic        load_en,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  byteen,
    output logic [31:0] wdata_rep,
    output logic [31:0] load_data
);

    logic [7:0]  rd_byte;
    logic [15:0] rd_half;

    always_comb begin
        byteen = 4'b0000;
        if (store_en) begin
            case (size)
                SZ_WORD: byteen = 4'b1111;
                SZ_HALF: byteen = addr_lo[1] ? 4'b1100 : 4'b0011;
                SZ_BYTE: byteen = 4'b0001 << addr_lo;
                default: byteen = 4'b0000;
            endcase
        end
    end

    // Replicate narrow stores so the enabled lane always carries the data.
    always_comb begin
        case (size)
            SZ_HALF: wdata_rep = {2{wdata[15:0]}};
            SZ_BYTE: wdata_rep = {4{wdata[7:0]}};
            default: wdata_rep = wdata;
        endcase
    end

    always_comb begin
        case (addr_lo)
            2'd0:    rd_byte = rdata[7:0];
            2'd1:    rd_byte = rdata[15:8];
            2'd2:    rd_byte = rdata[23:16];
            default: rd_byte = rdata[31:24];
        endcase
        rd_half = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    end

    always_comb begin
        load_data = 32'h0;
        if (load_en) begin
            case (size)
                SZ_BYTE: load_data = uns ? {24'h0, rd_byte}
                                         : {{24{rd_byte[7]}}, rd_byte};
                SZ_HALF: load_data = uns ? {16'h0, rd_half}
                                         : {{16{rd_half[15]}}, rd_half};
                default: load_data = rdata;
            endcase
        end
    end

endmodule

// File: rtl/mem_stage.sv
// MIPS memory stage: E/M register, address exception checks, bus request/ready FSM.
// Outputs follow the E/M register combinationally; Stall_Bus holds upstream while an access waits.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16,
    parameter logic [31:0] DM_TOP  = 32'h0000_2FFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Req,
    input  logic [31:0] Instr_M_In,
    input  logic [31:0] PC_M_In,
    input  logic [31:0] ALUOut_M_In,
    input  logic [31:0] WriteData_M_In,
    input  logic [4:0]  WriteReg_M_In,
    input  logic [4:0]  ExcCode_M_In,
    input  logic        isdelay_M_In,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    output logic [3:0]  m_byteen,
    output logic        m_req,
    input  logic [31:0] m_rdata,
    input  logic        m_ready,
    output logic        Stall_Bus,
    output logic [31:0] Instr_M_Out,
    output logic [31:0] PC_M_Out,
    output logic [31:0] ALUOut_M_Out,
    output logic [31:0] LoadData_M_Out,
    output logic [4:0]  WriteReg_M_Out,
    output logic [4:0]  ExcCode_M_Out,
    output logic        isdelay_M_Out
);

    localparam int unsigned   CNT_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_WAIT = 1'b1;

    em_reg_t          em_q;
    em_reg_t          em_d;
    logic [0:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    mem_op_t          op;
    logic [31:0]      addr;
    logic             is_access;
    logic             misaligned;
    logic             in_dm;
    logic             in_io;
    logic             addr_bad;
    logic [4:0]       fault_code;
    logic             access_vld;
    logic             timeout_now;

    assign em_d = '{instr:     Instr_M_In,
                    pc:        PC_M_In,
                    alu_out:   ALUOut_M_In,
                    wdata:     WriteData_M_In,
                    write_reg: WriteReg_M_In,
                    exc_code:  ExcCode_M_In,
                    isdelay:   isdelay_M_In};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            em_q <= '0;
        end else if (Req) begin
            em_q <= '0;
        end else if (!Stall_Bus) begin
            em_q <= em_d;
        end
    end

    assign Instr_M_Out    = em_q.instr;
    assign PC_M_Out       = em_q.pc;
    assign ALUOut_M_Out   = em_q.alu_out;
    assign WriteReg_M_Out = em_q.write_reg;
    assign isdelay_M_Out  = em_q.isdelay;

    assign op        = decode_op(em_q.instr[31:26]);
    assign addr      = em_q.alu_out;
    assign is_access = op.is_load | op.is_store;

    assign misaligned = ((op.size == SZ_WORD) && (addr[1:0] != 2'b00)) ||
                        ((op.size == SZ_HALF) && addr[0]);
    assign in_dm      = (addr <= DM_TOP);
    assign in_io      = in_range(addr, TC0_LO, TC0_HI) |
                        in_range(addr, TC1_LO, TC1_HI) |
                        in_range(addr, IG_LO, IG_HI);

    // Timer count registers are read-only; peripherals accept only full words.
    assign addr_bad = is_access &
                      (misaligned | !(in_dm | in_io) |
                       (in_io & (op.size != SZ_WORD)) |
                       (op.is_store & ((addr == TC0_COUNT) | (addr == TC1_COUNT))));

    assign fault_code = op.is_store ? EXC_ADES : EXC_ADEL;
    assign access_vld = is_access & (em_q.exc_code == EXC_NONE) & !addr_bad & !Req;

    assign timeout_now = access_vld & (state_q == ST_WAIT) & (cnt_q == CNT_LAST) & !m_ready;

    assign m_req     = access_vld;
    assign Stall_Bus = m_req & !m_ready & !timeout_now;
    assign m_addr    = {addr[31:2], 2'b00};

    always_comb begin
        ExcCode_M_Out = EXC_NONE;
        if (em_q.exc_code != EXC_NONE) begin
            ExcCode_M_Out = em_q.exc_code;
        end else if (addr_bad || timeout_now) begin
            ExcCode_M_Out = fault_code;
        end
    end

    // Any loss of validity (Req flush) or completion returns to IDLE with a fresh count.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (access_vld && !m_ready) begin
                    state_d = ST_WAIT;
                    cnt_d   = CNT_W'(1);
                end
            end
            ST_WAIT: begin
                if (!access_vld || m_ready || (cnt_q == CNT_LAST)) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    mem_align u_align (
        .size      (op.size),
        .uns       (op.uns),
        .addr_lo   (addr[1:0]),
        .store_en  (access_vld & op.is_store),
        .load_en   (access_vld & op.is_load & m_ready),
        .wdata     (em_q.wdata),
        .rdata     (m_rdata),
        .byteen    (m_byteen),
        .wdata_rep (m_wdata),
        .load_data (LoadData_M_Out)
    );

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory stage of the five-stage MIPS pipeline. Holds the E/M pipeline register and consumes the Execute stage's outputs: instruction, PC, ALU result, store data, write register, exception code and delay-slot flag.
- Drives the data bus through a ready/request handshake with bounded wait states.
- Generates byte enables, aligns and extends load data, and adds the address exceptions (AdEL/AdES).
- Stalls the pipeline upstream while a bus access is outstanding.

Parameters:
- TIMEOUT, 16, number of cycles waited for m_ready before the access is aborted with an exception
- DM_TOP, 32'h0000_2FFF, highest valid data-memory byte address

Ports:
- clk  in  1  pipeline clock
- reset  in  1  asynchronous, active-high; clears the register and the FSM
- Req  in  1  exception/interrupt taken; flushes the E/M register and aborts any bus access
- Instr_M_In, PC_M_In, ALUOut_M_In, WriteData_M_In  in  32 each  from Execute
- WriteReg_M_In  in  5  from Execute
- ExcCode_M_In  in  5  from Execute
- isdelay_M_In  in  1  from Execute
- m_addr  out  32  bus byte address (word-aligned, i.e. ALUOut with bits [1:0] forced to 0)
- m_wdata  out  32  store data replicated into lanes
- m_byteen  out  4  write byte enables
- m_req  out  1  bus access request
- m_rdata  in  32  bus read data
- m_ready  in  1  bus completes the access this cycle
- Stall_Bus  out  1  freezes the PC and the F/D, D/E and E/M registers
- Instr_M_Out, PC_M_Out, ALUOut_M_Out, LoadData_M_Out  out  32 each
- WriteReg_M_Out  out  5
- ExcCode_M_Out  out  5
- isdelay_M_Out  out  1

Behaviour:
- E/M register, rising clk:
  - Priority 1: reset (asynchronous) or Req → all fields 0 (Instr=0 is a nop).
  - Priority 2: Stall_Bus → hold.
  - Otherwise load the _In values.
  - Reset value of every registered output: 0.
  - Req has priority over Stall_Bus.
- Decode: lw, lh, lhu, lb, lbu, sw, sh, sb. Every other opcode is a non-access.
- Address checks; any failure gives AdEL=4 for a load, AdES=5 for a store:
  - misalignment: word needs addr[1:0]=0, half needs addr[0]=0;
  - addr outside [0, DM_TOP], [0x7F00, 0x7F0B], [0x7F10, 0x7F1B] and [0x7F20, 0x7F23];
  - a non-word access to the 0x7Fxx timer/IG ranges;
  - a store to 0x7F08 or 0x7F18 (timer count registers);
  - for AdES, a store-address overflow carried from Execute keeps its Execute code.
- ExcCode_M_Out priority:
  - ExcCode_M_In if nonzero;
  - else the check result above;
  - else the timeout code (4 for a load, 5 for a store);
  - else 0.
- Access is valid when: a load/store, ExcCode_M_In=0, checks pass, !Req.
- m_byteen, asserted only for a valid store:
  - sw=1111;
  - sh=0011 or 1100 by addr[1];
  - sb=one-hot 1<<addr[1:0].
- m_wdata: sh puts data[15:0] in both halves; sb puts data[7:0] in all four bytes.
- FSM, states IDLE and WAIT, with a cycle counter cnt:
  - IDLE: if the access is valid, assert m_req. On m_ready the access completes with zero wait. Otherwise go to WAIT with cnt=1.
  - WAIT: hold m_req and the address/data.
    - m_ready → IDLE.
    - else if cnt==TIMEOUT-1 → IDLE with the timeout flag set; the instruction leaves M with the timeout code.
    - else cnt++.
  - Req in any state → IDLE, cnt=0, m_req=0 in the same cycle (combinational gate), and no write lands.
- Stall_Bus = m_req & !m_ready & !timeout_now.
- The timeout flag clears when the E/M register loads.
- LoadData_M_Out is computed combinationally from m_rdata in the m_ready cycle, selected by addr[1:0]:
  - lb/lh sign-extend; lbu/lhu zero-extend; lw passes through.
  - 0 when there is no valid load.
- The data is consumed by M/W on the edge where Stall_Bus drops.

Decomposition:
- Shared package: opcode constants, ExcCode constants (AdEL=4, AdES=5, Ov=12), address-map bounds.
- One sub-module: mem_align, which is combinational and produces byteen, wdata replication and load extension.
- The FSM, counter, register and checks stay in mem_stage.

Test Plan:
- sh, addr=0x0000_0006, data=0x1234ABCD, m_ready same cycle → m_byteen=1100, m_wdata=0xABCDABCD, Stall_Bus=0, ExcCode=0.
- lb, addr=0x3, m_rdata=0x80FF_0000 after 2 wait cycles → Stall_Bus high for 2 cycles; LoadData=0xFFFF_FF80 (lbu: 0x0000_0080).
- lw at 0x0000_3000 → ExcCode_M_Out=4, m_req=0. sw at 0x7F08 → ExcCode_M_Out=5, m_byteen=0000.
- ExcCode_M_In=12 with sw → passes 12, no bus access.
- m_ready never asserted, TIMEOUT=16 → Stall_Bus high for 15 cycles, then the instruction advances with ExcCode 4 or 5.
- Req asserted in the 3rd WAIT cycle → m_req drops in the same cycle, E/M register is 0 next edge, FSM in IDLE. Async reset mid-WAIT → all outputs 0 immediately.
